// File: rtl/sdram_frame_writer_pkg.sv
// Shared definitions for the SDRAM frame writer and its reader-side FIFO loader.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package sdram_frame_writer_pkg;

  // Address field widths: {frame, line, word} forms the SDRAM word address.
  localparam int FRAME_W = 6;
  localparam int LINE_W  = 10;
  localparam int WORD_W  = 9;
  localparam int ADDR_W  = FRAME_W + LINE_W + WORD_W;

  // Default frame geometry in 16-bit words per line and lines per frame.
  localparam int DEF_H_WORDS = 512;
  localparam int DEF_V_LINES = 768;

  // Writer FSM encoding, kept as plain constants so older tools and the
  // loader side can compare against the same raw values.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LO    = 3'd1;
  localparam logic [2:0] ST_HI    = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Structured view of an SDRAM word address.
  typedef struct packed {
    logic [FRAME_W-1:0] frame;
    logic [LINE_W-1:0]  line;
    logic [WORD_W-1:0]  word;
  } wr_addr_t;

endpackage

// File: rtl/sdram_frame_writer_if.sv
// Pixel-in / SDRAM-write-out signal bundle for the frame writer.
// Latency: n/a (wiring only).
// Backpressure: oPIX_READY gates pixel bytes, iWAIT_REQUEST stalls writes.
interface sdram_frame_writer_if;
  import sdram_frame_writer_pkg::*;

  logic               iSTART;
  logic [FRAME_W-1:0] iFRAME_ID;
  logic [7:0]         iPIX_DATA;
  logic               iPIX_VALID;
  logic               oPIX_READY;
  logic               iWAIT_REQUEST;
  logic               oWR_EN;
  logic [ADDR_W-1:0]  oWR_ADDR;
  logic [15:0]        oWR_DATA;
  logic               oBUSY;
  logic               oFRAME_DONE;

  // Source side: pixel producer plus SDRAM port model.
  modport master (
    output iSTART, iFRAME_ID, iPIX_DATA, iPIX_VALID, iWAIT_REQUEST,
    input  oPIX_READY, oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oFRAME_DONE
  );

  // Writer side.
  modport slave (
    input  iSTART, iFRAME_ID, iPIX_DATA, iPIX_VALID, iWAIT_REQUEST,
    output oPIX_READY, oWR_EN, oWR_ADDR, oWR_DATA, oBUSY, oFRAME_DONE
  );

endinterface

// File: rtl/byte_packer_16.sv
// Packs two accepted pixel bytes (low first, then high) into one 16-bit word.
// Latency: word_dat holds the new high byte one cycle after it is accepted.
// Backpressure: consumes a byte only when byte_vld and byte_rdy are both high.
module byte_packer_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_dat,
  input  logic        byte_vld,
  input  logic        byte_rdy,
  input  logic        hi_sel,
  output logic [15:0] word_dat,
  output logic        word_vld
);

  logic take;

  assign take     = byte_vld & byte_rdy;
  // Strobe on the byte that completes the word; the caller moves on next cycle.
  assign word_vld = take & hi_sel;

  // Steer each accepted byte into its half; the word holds while no byte is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_dat <= 16'h0000;
    end else if (take) begin
      if (hi_sel) begin
        word_dat[15:8] <= byte_dat;
      end else begin
        word_dat[7:0] <= byte_dat;
      end
    end
  end

endmodule

// File: rtl/sdram_frame_writer.sv
// Streams one frame of pixel bytes into SDRAM as 16-bit words, line by line.
// Latency: write request one cycle after the high byte; one word per 3 cycles.
// Backpressure: holds the request stable under iWAIT_REQUEST; no bytes taken then.
module sdram_frame_writer
  import sdram_frame_writer_pkg::*;
#(
  parameter int P_H_WORDS = DEF_H_WORDS,
  parameter int P_V_LINES = DEF_V_LINES
) (
  input logic                 iCLK,
  input logic                 iRST_N,
  sdram_frame_writer_if.slave bus
);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(P_H_WORDS - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(P_V_LINES - 1);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [FRAME_W-1:0] frame_q;
  logic [LINE_W-1:0]  line_cnt;
  logic [WORD_W-1:0]  word_cnt;
  logic [15:0]        word_dat;
  logic               word_vld;
  logic               pix_take;
  logic               start_take;
  logic               wr_take;
  logic               last_word;
  logic               last_xfer;
  wr_addr_t           addr_s;

  assign start_take = (state == ST_IDLE) & bus.iSTART;
  assign pix_take   = bus.iPIX_VALID & bus.oPIX_READY;
  assign wr_take    = (state == ST_WRITE) & ~bus.iWAIT_REQUEST;
  assign last_word  = (word_cnt == LAST_WORD);
  assign last_xfer  = last_word & (line_cnt == LAST_LINE);

  byte_packer_16 u_packer (
    .clk      (iCLK),
    .rst_n    (iRST_N),
    .byte_dat (bus.iPIX_DATA),
    .byte_vld (bus.iPIX_VALID),
    .byte_rdy (bus.oPIX_READY),
    .hi_sel   (state == ST_HI),
    .word_dat (word_dat),
    .word_vld (word_vld)
  );

  // Next-state selection: bytes advance LO->HI->WRITE, a granted write loops back or finishes.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.iSTART) state_nxt = ST_LO;
      ST_LO:    if (pix_take) state_nxt = ST_HI;
      ST_HI:    if (word_vld) state_nxt = ST_WRITE;
      ST_WRITE: if (wr_take) state_nxt = last_xfer ? ST_DONE : ST_LO;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset drops any frame in flight, including a stalled write.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame slot and position counters; they only move on a start or a granted write.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      frame_q  <= '0;
      line_cnt <= '0;
      word_cnt <= '0;
    end else if (start_take) begin
      frame_q  <= bus.iFRAME_ID;
      line_cnt <= '0;
      word_cnt <= '0;
    end else if (wr_take) begin
      if (last_word) begin
        // The final line increment lands past the frame, but DONE follows so it is never issued.
        word_cnt <= '0;
        line_cnt <= line_cnt + LINE_W'(1);
      end else begin
        word_cnt <= word_cnt + WORD_W'(1);
      end
    end
  end

  assign addr_s = '{frame: frame_q, line: line_cnt, word: word_cnt};

  // All outputs decode from registered state, so reset clears them without a clock edge.
  assign bus.oPIX_READY  = (state == ST_LO) | (state == ST_HI);
  assign bus.oWR_EN      = (state == ST_WRITE);
  assign bus.oWR_ADDR    = addr_s;
  assign bus.oWR_DATA    = word_dat;
  assign bus.oBUSY       = (state != ST_IDLE);
  assign bus.oFRAME_DONE = (state == ST_DONE);

endmodule

// File: tb/tb_sdram_frame_writer.sv
module tb_sdram_frame_writer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc_n;

  sdram_frame_writer_if a ();
  sdram_frame_writer_if b ();

  sdram_frame_writer #(.P_H_WORDS(4), .P_V_LINES(2)) u_dut_a (
    .iCLK(clk), .iRST_N(rst_n), .bus(a)
  );

  sdram_frame_writer #(.P_V_LINES(2)) u_dut_b (
    .iCLK(clk), .iRST_N(rst_n), .bus(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_n = 0;
  always @(posedge clk) cyc_n = cyc_n + 1;

  // Write/done monitors, sampled mid-cycle.
  logic [24:0] a_addr[$];
  logic [15:0] a_data[$];
  int          a_cyc[$];
  int          a_done;
  logic [24:0] b_addr[$];
  logic [15:0] b_data[$];
  int          b_done;

  initial begin
    a_done = 0;
    b_done = 0;
  end

  always @(negedge clk) begin
    if (a.oWR_EN && !a.iWAIT_REQUEST) begin
      a_addr.push_back(a.oWR_ADDR);
      a_data.push_back(a.oWR_DATA);
      a_cyc.push_back(cyc_n);
    end
    if (a.oFRAME_DONE) a_done = a_done + 1;
    if (b.oWR_EN && !b.iWAIT_REQUEST) begin
      b_addr.push_back(b.oWR_ADDR);
      b_data.push_back(b.oWR_DATA);
    end
    if (b.oFRAME_DONE) b_done = b_done + 1;
  end

  task automatic clear_mon();
    a_addr.delete();
    a_data.delete();
    a_cyc.delete();
  endtask

  task automatic set_pix(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      b.iPIX_VALID = v;
      b.iPIX_DATA  = d;
    end else begin
      a.iPIX_VALID = v;
      a.iPIX_DATA  = d;
    end
  endtask

  task automatic start(input bit sel, input logic [5:0] id);
    @(posedge clk); #1;
    if (sel) begin b.iSTART = 1'b1; b.iFRAME_ID = id; end
    else     begin a.iSTART = 1'b1; a.iFRAME_ID = id; end
    @(posedge clk); #1;
    if (sel) b.iSTART = 1'b0;
    else     a.iSTART = 1'b0;
  endtask

  // Sends n bytes base, base+1, ... with valid held high; ok=0 if the budget runs out.
  task automatic feed(input bit sel, input int n, input int base, output bit ok);
    int sent = 0;
    int cyc  = 0;
    bit acc;
    set_pix(sel, 1'b1, 8'(base));
    while (sent < n && cyc < 20 * n + 50) begin
      @(negedge clk);
      acc = sel ? (b.iPIX_VALID && b.oPIX_READY) : (a.iPIX_VALID && a.oPIX_READY);
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        set_pix(sel, sent < n, 8'(base + sent));
      end
      cyc++;
    end
    set_pix(sel, 1'b0, 8'h00);
    ok = (sent == n);
  endtask

  task automatic wait_done(input bit sel, input int d0, output bit ok);
    int t = 0;
    while ((sel ? b_done : a_done) == d0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    ok = ((sel ? b_done : a_done) != d0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a.iSTART = 0; a.iFRAME_ID = 0; a.iPIX_DATA = 0; a.iPIX_VALID = 0; a.iWAIT_REQUEST = 0;
    b.iSTART = 0; b.iFRAME_ID = 0; b.iPIX_DATA = 0; b.iPIX_VALID = 0; b.iWAIT_REQUEST = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (a.oWR_EN !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", a.oWR_EN); end
    checks++; if (a.oPIX_READY !== 1'b0) begin failures++; $display("FAIL reset_pix_ready: got %b expected 0", a.oPIX_READY); end
    checks++; if (a.oBUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", a.oBUSY); end
    checks++; if (a.oFRAME_DONE !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", a.oFRAME_DONE); end
    checks++; if (a.oWR_ADDR !== 25'h0) begin failures++; $display("FAIL reset_addr: got %h expected 0", a.oWR_ADDR); end
    checks++; if (a.oWR_DATA !== 16'h0) begin failures++; $display("FAIL reset_data: got %h expected 0", a.oWR_DATA); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    a.iPIX_VALID = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (a.oBUSY !== 1'b0 || a.oPIX_READY !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: busy=%b ready=%b expected 0/0", a.oBUSY, a.oPIX_READY);
    end
    a.iPIX_VALID = 1'b0;
  endtask

  task automatic test_frame();
    bit ok;
    int d0;
    logic [24:0] ea;
    logic [15:0] ed;
    clear_mon();
    d0 = a_done;
    a.iWAIT_REQUEST = 1'b0;
    start(0, 6'd5);
    feed(0, 16, 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL frame_feed_timeout: bytes not all accepted"); end
    wait_done(0, d0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL frame_done_timeout: no done pulse"); end
    checks++; if (a.oBUSY !== 1'b0 || a.oFRAME_DONE !== 1'b0) begin
      failures++; $display("FAIL frame_idle_after_done: busy=%b done=%b expected 0/0", a.oBUSY, a.oFRAME_DONE);
    end
    checks++; if (a_addr.size() != 8) begin failures++; $display("FAIL frame_write_count: got %0d expected 8", a_addr.size()); end
    for (int k = 0; k < 8 && k < a_addr.size(); k++) begin
      ea = {6'd5, 10'(k / 4), 9'(k % 4)};
      ed = {8'(2 * k + 2), 8'(2 * k + 1)};
      checks++; if (a_addr[k] !== ea || a_data[k] !== ed) begin
        failures++; $display("FAIL frame_write_%0d: got %h/%h expected %h/%h", k, a_addr[k], a_data[k], ea, ed);
      end
      if (k > 0) begin
        checks++; if (a_cyc[k] - a_cyc[k-1] != 3) begin
          failures++; $display("FAIL frame_spacing_%0d: got %0d cycles expected 3", k, a_cyc[k] - a_cyc[k-1]);
        end
      end
    end
    repeat (5) @(posedge clk); #1;
    checks++; if (a_done != d0 + 1) begin failures++; $display("FAIL frame_done_count: got %0d expected %0d", a_done - d0, 1); end
  endtask

  task automatic test_stall();
    bit ok;
    int d0;
    clear_mon();
    d0 = a_done;
    a.iWAIT_REQUEST = 1'b1;
    start(0, 6'd5);
    feed(0, 2, 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_feed_timeout: first word not accepted"); end
    set_pix(0, 1'b1, 8'h77);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (a.oWR_EN !== 1'b1 || a.oWR_ADDR !== 25'h0280000 || a.oWR_DATA !== 16'h0201 || a.oPIX_READY !== 1'b0) begin
        failures++; $display("FAIL stall_hold_%0d: en=%b addr=%h data=%h rdy=%b expected 1/0280000/0201/0",
                             i, a.oWR_EN, a.oWR_ADDR, a.oWR_DATA, a.oPIX_READY);
      end
      @(posedge clk); #1;
      if (i == 4) a.iWAIT_REQUEST = 1'b0;
    end
    set_pix(0, 1'b0, 8'h00);
    checks++; if (a_addr.size() != 1) begin failures++; $display("FAIL stall_one_transfer: got %0d expected 1", a_addr.size()); end
    feed(0, 14, 3, ok);
    wait_done(0, d0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_done_timeout: no done pulse"); end
    checks++; if (a_addr.size() != 8 || a_addr[a_addr.size()-1] !== 25'h0280203 || a_data[a_data.size()-1] !== 16'h100F) begin
      failures++; $display("FAIL stall_last_write: count=%0d expected 8 with last 0280203/100f", a_addr.size());
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    int d0;
    logic [24:0] ea;
    clear_mon();
    d0 = a_done;
    start(0, 6'd5);
    feed(0, 6, 1, ok);
    a.iSTART = 1'b1;
    a.iFRAME_ID = 6'd9;
    @(posedge clk); #1;
    a.iSTART = 1'b0;
    checks++; if (a.oBUSY !== 1'b1) begin failures++; $display("FAIL restart_busy: got %b expected 1", a.oBUSY); end
    feed(0, 10, 7, ok);
    wait_done(0, d0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL restart_done_timeout: no done pulse"); end
    checks++; if (a_addr.size() != 8) begin failures++; $display("FAIL restart_count: got %0d expected 8", a_addr.size()); end
    for (int k = 0; k < a_addr.size(); k++) begin
      ea = {6'd5, 10'(k / 4), 9'(k % 4)};
      checks++; if (a_addr[k] !== ea) begin
        failures++; $display("FAIL restart_addr_%0d: got %h expected %h", k, a_addr[k], ea);
      end
    end
  endtask

  task automatic test_gap_and_reset();
    clear_mon();
    a.iWAIT_REQUEST = 1'b1;
    start(0, 6'd5);
    set_pix(0, 1'b1, 8'hA5);
    @(negedge clk);
    checks++; if (a.oPIX_READY !== 1'b1) begin failures++; $display("FAIL gap_ready_lo: got %b expected 1", a.oPIX_READY); end
    @(posedge clk); #1;
    set_pix(0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (a.oWR_EN !== 1'b0 || a.oPIX_READY !== 1'b1) begin
        failures++; $display("FAIL gap_hold_%0d: en=%b rdy=%b expected 0/1", i, a.oWR_EN, a.oPIX_READY);
      end
      @(posedge clk); #1;
    end
    set_pix(0, 1'b1, 8'h5A);
    @(posedge clk); #1;
    set_pix(0, 1'b0, 8'h00);
    @(negedge clk);
    checks++; if (a.oWR_EN !== 1'b1 || a.oWR_DATA !== 16'h5AA5 || a.oWR_ADDR !== 25'h0280000) begin
      failures++; $display("FAIL gap_word: en=%b data=%h addr=%h expected 1/5aa5/0280000", a.oWR_EN, a.oWR_DATA, a.oWR_ADDR);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (a.oWR_EN !== 1'b0 || a.oBUSY !== 1'b0 || a.oWR_ADDR !== 25'h0 || a.oWR_DATA !== 16'h0) begin
      failures++; $display("FAIL async_reset: en=%b busy=%b addr=%h data=%h expected all 0",
                           a.oWR_EN, a.oBUSY, a.oWR_ADDR, a.oWR_DATA);
    end
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    a.iWAIT_REQUEST = 1'b0;
    set_pix(0, 1'b1, 8'h33);
    repeat (20) @(posedge clk); #1;
    set_pix(0, 1'b0, 8'h00);
    checks++; if (a_addr.size() != 0) begin failures++; $display("FAIL reset_no_write: got %0d writes expected 0", a_addr.size()); end
    checks++; if (a.oBUSY !== 1'b0) begin failures++; $display("FAIL reset_stays_idle: busy=%b expected 0", a.oBUSY); end
  endtask

  task automatic test_default_geom();
    bit ok;
    int bad = 0;
    logic [24:0] ea;
    logic [15:0] ed;
    b.iWAIT_REQUEST = 1'b0;
    start(1, 6'd63);
    feed(1, 2048, 1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL geom_feed_timeout: bytes not all accepted"); end
    wait_done(1, 0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL geom_done_timeout: no done pulse"); end
    checks++; if (b_addr.size() != 1024) begin failures++; $display("FAIL geom_count: got %0d expected 1024", b_addr.size()); end
    if (b_addr.size() == 1024) begin
      checks++; if (b_addr[511] !== 25'h1F801FF) begin failures++; $display("FAIL geom_line0_end: got %h expected 1f801ff", b_addr[511]); end
      checks++; if (b_addr[512] !== 25'h1F80200) begin failures++; $display("FAIL geom_wrap: got %h expected 1f80200", b_addr[512]); end
      checks++; if (b_addr[1023] !== 25'h1F803FF || b_data[1023] !== 16'h00FF) begin
        failures++; $display("FAIL geom_last: got %h/%h expected 1f803ff/00ff", b_addr[1023], b_data[1023]);
      end
      for (int k = 0; k < 1024; k++) begin
        ea = {6'd63, 10'(k / 512), 9'(k % 512)};
        ed = {8'(2 * k + 2), 8'(2 * k + 1)};
        if (b_addr[k] !== ea || b_data[k] !== ed) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL geom_all_words: got %0d bad words expected 0", bad); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_frame();
    test_stall();
    test_start_ignored();
    test_gap_and_reset();
    test_default_geom();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
